// File: rtl/ray_req_arb.sv
// Round-robin arbiter: NUM_IN valid/stall producers share one registered downstream stage.
// Optional counters (grant_cnt, hold_cnt, idle_cnt) are built when RAY_REQ_ARB_STATS_EN is defined.
module ray_req_arb #(
    parameter int NUM_IN = 3,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        us_valid,
    input  logic [NUM_IN*DATA_W-1:0] us_data,
    output logic [NUM_IN-1:0]        us_stall,
    output logic                     ds_valid,
    output logic [DATA_W-1:0]        ds_data,
    output logic [SRC_W-1:0]         ds_src,
    input  logic                     ds_stall
`ifdef RAY_REQ_ARB_STATS_EN
    ,
    output logic [NUM_IN*32-1:0]     grant_cnt,
    output logic [31:0]              hold_cnt,
    output logic [31:0]              idle_cnt
`endif
);

    localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_IN - 1);
    localparam logic [SRC_W:0]   NUM_IN_X = (SRC_W + 1)'(NUM_IN);

    logic                r_ds_valid;
    logic [DATA_W-1:0]   r_ds_data;
    logic [SRC_W-1:0]    r_ds_src;
    logic [SRC_W-1:0]    r_last;

    logic                w_load_en;
    logic [SRC_W-1:0]    w_shift;
    logic [NUM_IN-1:0]   w_rot;
    logic [SRC_W-1:0]    w_off;
    logic [SRC_W:0]      w_sum;
    logic [SRC_W-1:0]    w_gidx;
    logic                w_any;
    logic [NUM_IN-1:0]   w_grant;
    logic [DATA_W-1:0]   w_gdata;

    // Handshake: a beat moves on any clock edge where valid=1 and stall=0; a stalled
    // producer keeps valid and data unchanged until that edge.
    assign w_load_en = ~r_ds_valid | ~ds_stall;
    assign us_stall  = ~({NUM_IN{w_load_en}} & w_grant);

    // Rotate the request vector so the search always starts at bit 0 = (last+1) mod NUM_IN.
    always_comb begin
        w_shift = (r_last == LAST_RST) ? '0 : r_last + 1'b1;
        w_rot   = NUM_IN'({us_valid, us_valid} >> w_shift);
        w_any   = |us_valid;
        w_off   = '0;
        for (int j = NUM_IN - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = SRC_W'(j);
        end
        w_sum   = {1'b0, w_shift} + {1'b0, w_off};
        w_gidx  = (w_sum >= NUM_IN_X) ? SRC_W'(w_sum - NUM_IN_X) : w_sum[SRC_W-1:0];
        w_grant = w_any ? (NUM_IN'(1) << w_gidx) : '0;
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) w_gdata = us_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ds_valid <= 1'b0;
            r_ds_data  <= '0;
            r_ds_src   <= '0;
            r_last     <= LAST_RST;
        end else if (w_load_en) begin
            r_ds_valid <= w_any;
            if (w_any) begin
                r_ds_data <= w_gdata;
                r_ds_src  <= w_gidx;
                r_last    <= w_gidx;
            end
        end
    end

    assign ds_valid = r_ds_valid;
    assign ds_data  = r_ds_data;
    assign ds_src   = r_ds_src;

`ifdef RAY_REQ_ARB_STATS_EN
    logic [31:0] r_grant_cnt [NUM_IN];
    logic [31:0] r_hold_cnt;
    logic [31:0] r_idle_cnt;

    // All counters saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) r_grant_cnt[i] <= '0;
            r_hold_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (us_valid[i] && !us_stall[i] && r_grant_cnt[i] != 32'hFFFF_FFFF)
                    r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
            end
            if (r_ds_valid && ds_stall && r_hold_cnt != 32'hFFFF_FFFF)
                r_hold_cnt <= r_hold_cnt + 32'd1;
            if (!r_ds_valid && !w_any && r_idle_cnt != 32'hFFFF_FFFF)
                r_idle_cnt <= r_idle_cnt + 32'd1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) grant_cnt[i*32 +: 32] = r_grant_cnt[i];
    end

    assign hold_cnt = r_hold_cnt;
    assign idle_cnt = r_idle_cnt;
`endif

endmodule

// File: tb/tb_ray_req_arb.sv
// Bench for ray_req_arb: directed vector table, then a random phase checked by a
// reference model and a payload scoreboard. Stats checks apply when RAY_REQ_ARB_STATS_EN is set.
module tb_ray_req_arb;

    localparam int NUM_IN = 3;
    localparam int DATA_W = 64;
    localparam int SRC_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN-1:0]        us_valid;
    logic [NUM_IN*DATA_W-1:0] us_data;
    logic [NUM_IN-1:0]        us_stall;
    logic                     ds_valid;
    logic [DATA_W-1:0]        ds_data;
    logic [SRC_W-1:0]         ds_src;
    logic                     ds_stall;
`ifdef RAY_REQ_ARB_STATS_EN
    logic [NUM_IN*32-1:0]     grant_cnt;
    logic [31:0]              hold_cnt;
    logic [31:0]              idle_cnt;
    logic [31:0]              hold_base;
`endif

    ray_req_arb #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .us_valid (us_valid),
        .us_data  (us_data),
        .us_stall (us_stall),
        .ds_valid (ds_valid),
        .ds_data  (ds_data),
        .ds_src   (ds_src),
        .ds_stall (ds_stall)
`ifdef RAY_REQ_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt),
        .hold_cnt (hold_cnt),
        .idle_cnt (idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic        st;
        logic        chk_stall;
        logic [2:0]  exp_stall;
        logic        exp_dv;
        logic [1:0]  exp_src;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(int r, int v, int st, int c, int es, int dv, int src, logic [63:0] d);
        vec_t x;
        x.rst = 1'(r); x.v = 3'(v); x.st = 1'(st); x.chk_stall = 1'(c);
        x.exp_stall = 3'(es); x.exp_dv = 1'(dv); x.exp_src = 2'(src); x.exp_data = d;
        return x;
    endfunction

    // Random-phase state
    logic [NUM_IN-1:0]         r_val;
    logic [DATA_W-1:0]         r_dat [NUM_IN];
    int                        wait_cnt [NUM_IN];
    logic [SRC_W+DATA_W-1:0]   exp_q [$];
    logic [SRC_W+DATA_W-1:0]   exp_item;
    logic [NUM_IN-1:0]         exp_st;
    int                        m_last, m_g, prev, winner, seq;
    logic                      m_dv, m_load;

    task automatic pop_check(input string name);
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: output src=%0d data=%0h with nothing expected", name, ds_src, ds_data);
        end else begin
            exp_item = exp_q.pop_front();
            chk(name, 128'({ds_src, ds_data}), 128'(exp_item));
        end
    endtask

    initial begin
        rst = 1'b1; us_valid = '0; ds_stall = 1'b0;
        us_data = {64'hC2, 64'hB1, 64'hA5};

        vecs[0]  = mk(1, 3'b000, 0, 0, 3'b111, 0, 0, 64'h0);
        vecs[1]  = mk(0, 3'b001, 0, 1, 3'b110, 1, 0, 64'hA5);
        vecs[2]  = mk(0, 3'b000, 0, 1, 3'b111, 0, 0, 64'hA5);
        vecs[3]  = mk(1, 3'b000, 0, 0, 3'b111, 0, 0, 64'h0);
        vecs[4]  = mk(0, 3'b111, 0, 1, 3'b110, 1, 0, 64'hA5);
        vecs[5]  = mk(0, 3'b111, 0, 1, 3'b101, 1, 1, 64'hB1);
        vecs[6]  = mk(0, 3'b111, 0, 1, 3'b011, 1, 2, 64'hC2);
        vecs[7]  = mk(0, 3'b111, 0, 1, 3'b110, 1, 0, 64'hA5);
        vecs[8]  = mk(0, 3'b111, 0, 1, 3'b101, 1, 1, 64'hB1);
        vecs[9]  = mk(0, 3'b111, 0, 1, 3'b011, 1, 2, 64'hC2);
        vecs[10] = mk(0, 3'b111, 0, 1, 3'b110, 1, 0, 64'hA5);
        vecs[11] = mk(0, 3'b111, 0, 1, 3'b101, 1, 1, 64'hB1);
        vecs[12] = mk(0, 3'b111, 0, 1, 3'b011, 1, 2, 64'hC2);
        for (int k = 13; k <= 17; k++) vecs[k] = mk(0, 3'b110, 1, 1, 3'b111, 1, 2, 64'hC2);
        vecs[18] = mk(0, 3'b110, 0, 1, 3'b101, 1, 1, 64'hB1);
        vecs[19] = mk(0, 3'b100, 0, 1, 3'b011, 1, 2, 64'hC2);
        vecs[20] = mk(0, 3'b100, 0, 1, 3'b011, 1, 2, 64'hC2);
        vecs[21] = mk(0, 3'b110, 0, 1, 3'b101, 1, 1, 64'hB1);
        vecs[22] = mk(0, 3'b000, 1, 1, 3'b111, 1, 1, 64'hB1);
        vecs[23] = mk(1, 3'b111, 1, 0, 3'b111, 0, 0, 64'h0);
        vecs[24] = mk(0, 3'b111, 0, 1, 3'b110, 1, 0, 64'hA5);
        vecs[25] = mk(0, 3'b000, 1, 1, 3'b111, 1, 0, 64'hA5);
        vecs[26] = mk(0, 3'b000, 0, 1, 3'b111, 0, 0, 64'hA5);
        vecs[27] = mk(0, 3'b010, 1, 1, 3'b101, 1, 1, 64'hB1);

        // Directed table: drive, check combinational stall, clock, check registered output.
        for (int k = 0; k < 28; k++) begin
            rst      = vecs[k].rst;
            us_valid = vecs[k].v;
            ds_stall = vecs[k].st;
            #1;
            if (vecs[k].chk_stall)
                chk($sformatf("tbl%0d_us_stall", k), 128'(us_stall), 128'(vecs[k].exp_stall));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_ds_valid", k), 128'(ds_valid), 128'(vecs[k].exp_dv));
            chk($sformatf("tbl%0d_ds_src", k), 128'(ds_src), 128'(vecs[k].exp_src));
            chk($sformatf("tbl%0d_ds_data", k), 128'(ds_data), 128'(vecs[k].exp_data));
`ifdef RAY_REQ_ARB_STATS_EN
            if (k == 12) begin
                for (int i = 0; i < NUM_IN; i++)
                    chk($sformatf("grant_cnt%0d", i), 128'(grant_cnt[i*32 +: 32]), 128'(32'd3));
                hold_base = hold_cnt;
            end
            if (k == 17) chk("hold_cnt_plus5", 128'(hold_cnt), 128'(hold_base + 32'd5));
`endif
        end

        // Random phase
        rst = 1'b1; us_valid = '0; ds_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        r_val = '0; m_last = NUM_IN - 1; m_dv = 1'b0; prev = -1; seq = 0;
        for (int i = 0; i < NUM_IN; i++) begin r_dat[i] = '0; wait_cnt[i] = 0; end

        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!r_val[i] && $urandom_range(0, 1) == 1) begin
                    r_val[i] = 1'b1;
                    r_dat[i] = {8'(i), 24'(seq), 32'($urandom)};
                    seq++;
                end
                us_data[i*DATA_W +: DATA_W] = r_dat[i];
            end
            us_valid = r_val;
            ds_stall = ($urandom_range(0, 3) == 0);
            #1;

            m_load = !m_dv || !ds_stall;
            m_g = -1;
            for (int k = 1; k <= NUM_IN; k++) begin
                if (m_g < 0 && r_val[(m_last + k) % NUM_IN]) m_g = (m_last + k) % NUM_IN;
            end
            exp_st = '1;
            if (m_load && m_g >= 0) exp_st[m_g] = 1'b0;
            chk("rnd_us_stall", 128'(us_stall), 128'(exp_st));
            chk("rnd_ds_valid", 128'(ds_valid), 128'(m_dv));

            if (ds_valid && !ds_stall) pop_check("rnd_payload");

            winner = -1;
            for (int i = 0; i < NUM_IN; i++) begin
                if (us_valid[i] && !us_stall[i]) begin
                    winner = i;
                    exp_q.push_back({SRC_W'(i), r_dat[i]});
                end
            end
            if (winner >= 0) begin
                chk("rnd_wait_bound", 128'(wait_cnt[winner] < NUM_IN), 128'(1));
                if ((r_val & ~(NUM_IN'(1) << winner)) != '0)
                    chk("rnd_no_repeat", 128'(winner != prev), 128'(1));
                for (int i = 0; i < NUM_IN; i++)
                    if (i != winner && r_val[i]) wait_cnt[i]++;
                wait_cnt[winner] = 0;
                prev = winner;
                r_val[winner] = 1'b0;
            end

            @(posedge clk);
            if (m_load) begin
                m_dv = (m_g >= 0);
                if (m_g >= 0) m_last = m_g;
            end
            #1;
        end

        // Drain whatever is still held downstream.
        us_valid = '0; ds_stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (ds_valid) pop_check("drain_payload");
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ray_req_arb.md
Name: ray_req_arb

Overview:
- Round-robin arbiter sharing one downstream pipeline consumer (for example, a traversal or list cache port) among NUM_IN upstream ray-pipeline producers.
- All interfaces use the pipeline valid/stall handshake.
- Holds a single registered output stage: the winning request is captured and presented downstream one cycle after acceptance.
- Tags each output with the index of the source requester, so responses can be steered back and per-source fairness can be checked.

Parameters:
- NUM_IN, 3: number of requesters; legal range 2..8.
- DATA_W, 64: payload width in bits per requester.
- SRC_W, 2: width of the source tag; must satisfy 2**SRC_W >= NUM_IN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- us_valid  in  NUM_IN  per-requester valid.
- us_data  in  NUM_IN*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- us_stall  out  NUM_IN  per-requester stall.
- ds_valid  out  1  output register holds a request.
- ds_data  out  DATA_W  payload of the held request.
- ds_src  out  SRC_W  index of the requester that supplied ds_data.
- ds_stall  in  1  downstream stall.

Behaviour:
- Transfer rule: a transfer occurs on a cycle where valid=1 and stall=0 at a clock edge. Producers hold valid and data stable while stalled.
- load_en = ~ds_valid | ~ds_stall. The output register may capture a new request only when load_en=1.
- Grant selection (combinational):
  - Search from index (last+1) mod NUM_IN upward, wrapping.
  - The first i with us_valid[i]=1 wins (one-hot grant).
  - No valid requesters means no grant.
- us_stall[i] = ~(load_en & grant[i]).
  - Every non-granted requester is stalled.
  - All requesters are stalled while the output is held (ds_valid=1 and ds_stall=1).
- On a grant with load_en=1:
  - ds_data <= payload of the granted requester.
  - ds_src <= granted index.
  - ds_valid <= 1.
  - last <= granted index.
- If load_en=1 and there is no grant: ds_valid <= 0. ds_data and ds_src are don't-care but hold their previous values.
- If load_en=0: ds_valid, ds_data, ds_src and last are all unchanged.
- Latency: one cycle from upstream transfer to ds_valid.
- Throughput: one request per cycle while ds_stall=0.
- Simultaneous downstream drain and upstream load in the same cycle is required. Losing a cycle here is a bug.
- Fairness: a continuously valid requester is granted within NUM_IN grants. A requester never wins twice in a row while another requester is valid.
- last updates only on a grant. Idle cycles do not move the pointer.
- Reset values: ds_valid=0, ds_data=0, ds_src=0, last=NUM_IN-1 (so requester 0 has first priority).
  - us_stall is combinational; during reset it follows the load_en/grant equations with ds_valid=0.
- Reset asserted mid-operation: the held request is dropped (ds_valid=0 on the next cycle). Upstream is responsible for not counting a dropped request.
- Source indices >= NUM_IN never appear on ds_src.

Optional Feature:
- Macro: RAY_REQ_ARB_STATS_EN.
- Defined: adds output ports
  - grant_cnt (NUM_IN*32 bits): per-requester count of upstream transfers.
  - hold_cnt (32 bits): count of cycles with ds_valid & ds_stall.
  - idle_cnt (32 bits): count of cycles with ds_valid=0 and no us_valid.
  - All counters clear on rst and saturate at 32'hFFFF_FFFF without wrapping. Intended for bench and SignalTap debug.
- Not defined: the ports do not exist and no counter logic is synthesized. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then us_valid=3'b001, data0=64'hA5, ds_stall=0:
  - us_stall[0]=0 in the same cycle.
  - Next cycle: ds_valid=1, ds_data=64'hA5, ds_src=0.
- All three requesters held valid for 9 cycles, ds_stall=0:
  - ds_src sequence 0,1,2,0,1,2,0,1,2.
  - With the stats macro defined, each grant_cnt entry = 3.
- Output held: ds_stall=1 for 5 cycles while requesters 1 and 2 are valid:
  - ds_valid, ds_data and ds_src stay constant.
  - us_stall=3'b111 throughout.
  - hold_cnt increments by 5.
  - On ds_stall deassertion: drain and the next load happen in the same cycle, with no bubble.
- Pointer wrap:
  - After a grant to 2, only requester 2 valid: 2 is granted again (no other requester valid).
  - Then requesters 1 and 2 both valid: 1 wins next (search starts from 0, and 0 is not valid).
- Reset mid-stream with ds_valid=1 and ds_stall=1:
  - ds_valid=0 on the next cycle.
  - The first grant after reset goes to requester 0 when all three are valid.
- Random valid and stall stimulus for 10k cycles:
  - Each input sequence is checked against a scoreboard.
  - Every accepted payload appears exactly once, in per-source order.
  - Maximum wait for any continuously valid requester ≤ NUM_IN grants.
